// File: rtl/seq_writeback_regfile.sv
// Y86-64 SEQ write-back stage fused with the 15-entry register file, the sticky status register and the retire counter.
// Optional macro WB_BYPASS_EN: same-cycle forwarding of committing valM/valE onto the read ports.
module seq_writeback_regfile #(
  parameter int WIDTH     = 64,
  parameter int RSP_IDX   = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [3:0]           icode,
  input  logic [3:0]           rA,
  input  logic [3:0]           rB,
  input  logic [WIDTH-1:0]     valE,
  input  logic [WIDTH-1:0]     valM,
  input  logic                 Cnd,
  input  logic                 imem_error,
  input  logic                 dmem_error,
  input  logic [3:0]           srcA,
  input  logic [3:0]           srcB,
  output logic [WIDTH-1:0]     valA_rd,
  output logic [WIDTH-1:0]     valB_rd,
  output logic [2:0]           stat,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_t;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'(RSP_IDX);

  logic [WIDTH-1:0]     regs [15];
  stat_t                stat_q;
  stat_t                stat_eval;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [3:0]           dst_e;
  logic [3:0]           dst_m;
  logic                 commit;

  always_comb begin
    dst_e = RNONE;
    case (icode)
      4'h2:                     dst_e = Cnd ? rB : RNONE;
      4'h3, 4'h6:               dst_e = rB;
      4'h8, 4'h9, 4'hA, 4'hB:   dst_e = RSP;
      default:                  dst_e = RNONE;
    endcase
    dst_m = (icode == 4'h5 || icode == 4'hB) ? rA : RNONE;

    if (imem_error || dmem_error) stat_eval = S_ADR;
    else if (icode > 4'hB)        stat_eval = S_INS;
    else if (icode == 4'h0)       stat_eval = S_HLT;
    else                          stat_eval = S_AOK;
  end

  assign commit = instr_valid && (stat_q == S_AOK) && (stat_eval == S_AOK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 15; i++) regs[i] <= '0;
      stat_q <= S_AOK;
      cnt_q  <= '0;
    end else if (instr_valid && stat_q == S_AOK) begin
      if (stat_eval == S_AOK) begin
        // M port checked first so popq %rsp leaves valM in the stack pointer
        for (int unsigned i = 0; i < 15; i++) begin
          if (dst_m == 4'(i))      regs[i] <= valM;
          else if (dst_e == 4'(i)) regs[i] <= valE;
        end
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end else begin
        stat_q <= stat_eval;
      end
    end
  end

  always_comb begin
    valA_rd = (srcA == RNONE) ? '0 : regs[srcA];
    valB_rd = (srcB == RNONE) ? '0 : regs[srcB];
`ifdef WB_BYPASS_EN
    if (commit && srcA != RNONE) begin
      if (srcA == dst_m)      valA_rd = valM;
      else if (srcA == dst_e) valA_rd = valE;
    end
    if (commit && srcB != RNONE) begin
      if (srcB == dst_m)      valB_rd = valM;
      else if (srcB == dst_e) valB_rd = valE;
    end
`endif
  end

  assign stat       = stat_q;
  assign halted     = (stat_q != S_AOK);
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_seq_writeback_regfile.sv
// Self-checking bench for seq_writeback_regfile: per-cycle compare against a behavioural model plus literal spot checks.
module tb_seq_writeback_regfile;

  localparam int W  = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic [3:0]    icode = '0, rA = 4'hF, rB = 4'hF, srcA = 4'hF, srcB = 4'hF;
  logic [W-1:0]  valE = '0, valM = '0;
  logic          Cnd = 1'b0, imem_error = 1'b0, dmem_error = 1'b0;
  logic [W-1:0]  valA_rd, valB_rd;
  logic [2:0]    stat;
  logic          halted;
  logic [CW-1:0] retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 1'b1;

  seq_writeback_regfile #(.WIDTH(W), .RSP_IDX(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .icode(icode),
    .rA(rA), .rB(rB), .valE(valE), .valM(valM), .Cnd(Cnd),
    .imem_error(imem_error), .dmem_error(dmem_error), .srcA(srcA), .srcB(srcB),
    .valA_rd(valA_rd), .valB_rd(valB_rd), .stat(stat), .halted(halted),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural state of the Y86-64 register file
  logic [W-1:0]  m_regs [15];
  int            m_stat;
  logic [CW-1:0] m_cnt;

  function automatic int instr_status(input logic [3:0] ic, input logic ie, input logic de);
    if (ie || de) return 3;
    if (ic > 4'hB) return 4;
    if (ic == 4'h0) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] e_dest(input logic [3:0] ic, input logic [3:0] b, input logic c);
    if (ic == 4'h2) return c ? b : 4'hF;
    if (ic == 4'h3 || ic == 4'h6) return b;
    if (ic >= 4'h8 && ic <= 4'hB) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dest(input logic [3:0] ic, input logic [3:0] a);
    return (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
  endfunction

  function automatic bit will_commit();
    return instr_valid && m_stat == 1 && instr_status(icode, imem_error, dmem_error) == 1;
  endfunction

  function automatic logic [W-1:0] m_read(input logic [3:0] idx);
    logic [W-1:0] v;
    v = (idx == 4'hF) ? '0 : m_regs[idx];
`ifdef WB_BYPASS_EN
    if (will_commit() && idx != 4'hF) begin
      if (idx == m_dest(icode, rA))          v = valM;
      else if (idx == e_dest(icode, rB, Cnd)) v = valE;
    end
`endif
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) m_regs[i] = '0;
      m_stat = 1;
      m_cnt  = '0;
    end else if (instr_valid && m_stat == 1) begin
      int s;
      logic [3:0] de, dm;
      s  = instr_status(icode, imem_error, dmem_error);
      de = e_dest(icode, rB, Cnd);
      dm = m_dest(icode, rA);
      if (s == 1) begin
        if (de != 4'hF) m_regs[de] = valE;
        if (dm != 4'hF) m_regs[dm] = valM;
        m_cnt = m_cnt + 1'b1;
      end else begin
        m_stat = s;
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("model_stat",   W'(stat),       W'(m_stat));
      check("model_halted", W'(halted),     W'(m_stat != 1));
      check("model_cnt",    W'(retire_cnt), W'(m_cnt));
      check("model_valA",   valA_rd,        m_read(srcA));
      check("model_valB",   valB_rd,        m_read(srcB));
    end
  end

  // Called at posedge+1; returns at the following posedge+1
  task automatic issue(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic [W-1:0] e, input logic [W-1:0] m, input logic c,
                       input logic ie, input logic de);
    icode = ic; rA = a; rB = b; valE = e; valM = m; Cnd = c;
    imem_error = ie; dmem_error = de; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;
    icode = 4'h3; rB = 4'h9; valE = 64'hDEAD;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_stat",   W'(stat),       W'(1));
    check("rst_halted", W'(halted),     W'(0));
    check("rst_cnt",    W'(retire_cnt), W'(0));
    check("rst_reg2",   valA_rd,        W'(0));
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srcA = 4'd2;
    @(posedge clk); #1 rst_n = 1'b1;
    do_reset();

    issue(4'h3, 4'hF, 4'd2, 64'd35, 64'd0, 1'b0, 1'b0, 1'b0);
    check("irmovq_r2", valA_rd, 64'd35);
    check("irmovq_cnt", W'(retire_cnt), W'(1));
    issue(4'h6, 4'hF, 4'd2, 64'd132, 64'd0, 1'b0, 1'b0, 1'b0);
    check("opq_r2", valA_rd, 64'd132);

    srcB = 4'd5;
    issue(4'h2, 4'hF, 4'd5, 64'd120, 64'd0, 1'b0, 1'b0, 1'b0);
    check("cmov_nc_r5", valB_rd, 64'd0);
    check("cmov_nc_cnt", W'(retire_cnt), W'(3));
    issue(4'h2, 4'hF, 4'd5, 64'd120, 64'd0, 1'b1, 1'b0, 1'b0);
    check("cmov_c_r5", valB_rd, 64'd120);

    srcA = 4'd4; srcB = 4'd3;
    issue(4'hB, 4'd4, 4'hF, 64'h108, 64'hABC, 1'b0, 1'b0, 1'b0);
    check("popq_rsp_r4", valA_rd, 64'hABC);
    issue(4'hB, 4'd3, 4'hF, 64'h108, 64'hABC, 1'b0, 1'b0, 1'b0);
    check("popq_r3_r4", valA_rd, 64'h108);
    check("popq_r3_r3", valB_rd, 64'hABC);
    check("popq_cnt", W'(retire_cnt), W'(6));

    srcB = 4'd6;
    icode = 4'h3; rA = 4'hF; rB = 4'd6; valE = 64'd99; Cnd = 1'b0; instr_valid = 1'b1;
    #2;
`ifdef WB_BYPASS_EN
    check("bypass_same_cycle", valB_rd, 64'd99);
`else
    check("nobypass_same_cycle", valB_rd, 64'd0);
`endif
    @(posedge clk); #1 instr_valid = 1'b0;
    check("bypass_after_edge", valB_rd, 64'd99);

    srcA = 4'd1;
    issue(4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    check("halt_stat", W'(stat), W'(2));
    check("halt_halted", W'(halted), W'(1));
    issue(4'h3, 4'hF, 4'd1, 64'd7, 64'd0, 1'b0, 1'b0, 1'b0);
    check("sticky_r1", valA_rd, 64'd0);
    check("sticky_cnt", W'(retire_cnt), W'(7));
    check("sticky_stat", W'(stat), W'(2));

    srcA = 4'd2;
    do_reset();
    srcA = 4'd7;
    issue(4'h5, 4'd7, 4'd2, 64'd8, 64'h55, 1'b0, 1'b0, 1'b1);
    check("adr_stat", W'(stat), W'(3));
    check("adr_r7", valA_rd, 64'd0);
    check("adr_cnt", W'(retire_cnt), W'(0));

    srcA = 4'd2;
    do_reset();
    issue(4'hC, 4'd1, 4'd2, 64'd8, 64'd9, 1'b0, 1'b0, 1'b0);
    check("ins_stat", W'(stat), W'(4));

    do_reset();
    srcA = 4'd0; srcB = 4'd14;
    for (int i = 0; i < 16; i++)
      issue(4'h3, 4'hF, 4'(i % 15), W'(i * 3 + 1), 64'd0, 1'b0, 1'b0, 1'b0);
    check("wrap_cnt", W'(retire_cnt), W'(0));
    check("wrap_r0", valA_rd, W'(46));
    check("wrap_r14", valB_rd, W'(43));
    issue(4'h9, 4'hF, 4'hF, 64'h200, 64'h0, 1'b0, 1'b0, 1'b0);
    check("wrap_cnt_1", W'(retire_cnt), W'(1));

    @(posedge clk); #1;
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_writeback_regfile.md
Name: seq_writeback_regfile

Overview:
- Y86-64 SEQ write-back stage fused with the program register file.
- Accepts valE from execute and valM from memory, and derives dstE/dstM from icode/rA/rB/Cnd.
- Commits results on the clock edge and serves combinational srcA/srcB reads back to decode.
- Holds the processor status register (sticky AOK/HLT/ADR/INS) and a retired-instruction counter.

Parameters:
- WIDTH, 64, data width of registers, valE, valM and read ports.
- RSP_IDX, 4, register index used as the stack pointer for call/ret/pushq/popq.
- CNT_WIDTH, 32, width of the retire counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  one-cycle strobe: current icode/rA/rB/valE/valM/Cnd form a complete instruction to retire.
- icode  in  4  instruction code.
- rA  in  4  rA field; 0xF = none.
- rB  in  4  rB field; 0xF = none.
- valE  in  WIDTH  execute result.
- valM  in  WIDTH  memory read data.
- Cnd  in  1  condition flag from execute.
- imem_error  in  1  fetch address fault for this instruction.
- dmem_error  in  1  data memory fault for this instruction.
- srcA  in  4  read address A; 0xF returns 0.
- srcB  in  4  read address B; 0xF returns 0.
- valA_rd  out  WIDTH  register[srcA], combinational.
- valB_rd  out  WIDTH  register[srcB], combinational.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  out  1  high whenever stat != AOK.
- retire_cnt  out  CNT_WIDTH  count of instructions committed with stat AOK.

Behaviour:
- Reset (rst_n=0, asynchronous): all 15 registers = 0, stat = 1 (AOK), halted = 0, retire_cnt = 0. Reset asserted mid-instruction aborts that instruction; no partial write.
- dstE mapping:
  - icode 2: rB if Cnd=1, else 0xF.
  - icode 3 and 6: rB.
  - icode 8, 9, A, B: RSP_IDX.
  - All other icodes: 0xF.
- dstM mapping: icode 5 and B: rA; otherwise 0xF.
- Status evaluation for each instruction_valid cycle, in priority order:
  - imem_error or dmem_error → ADR.
  - icode > 0xB → INS.
  - icode 0 → HLT.
  - Otherwise AOK.
- Commit: on rising clk with instr_valid=1, stat==AOK and evaluated status AOK:
  - reg[dstE] <= valE if dstE != 0xF.
  - reg[dstM] <= valM if dstM != 0xF.
  - retire_cnt increments.
- Latency: one cycle; a write is visible on the read ports after the edge that commits it.
- Write collision (dstE == dstM, e.g. popq %rsp): the M port wins; the register takes valM.
- Faulting instruction (non-AOK status): no register write, no counter increment. stat loads the new code on that edge.
- Sticky halt: once stat != AOK, all later instr_valid strobes are ignored. There are no writes and no stat change until reset.
- instr_valid=0: no state change, regardless of other inputs.
- retire_cnt wraps from all-ones to 0 silently.
- Reads: pure combinational mux. Index 0xF returns 0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: forwarding on the read ports.
  - When instr_valid=1 and the instruction will commit, srcA/srcB equal to dstM return valM.
  - Otherwise, if equal to dstE, they return valE (M has priority over E).
  - This is write-through within the same cycle.
- Undefined: read ports return only the stored register contents; the new value appears the cycle after the commit edge.

Test Plan:
- Reset: drive rst_n=0 asynchronously between edges → regs read 0, stat=1, halted=0, retire_cnt=0 immediately.
- irmovq then OPq:
  - icode=3, rB=2, valE=35, strobe → srcA=2 reads 35 next cycle, retire_cnt=1.
  - icode=6, rB=2, valE=132, strobe → srcA=2 reads 132.
- cmovXX gating:
  - icode=2, rB=5, valE=120, Cnd=0 → reg5 stays 0, retire_cnt still increments.
  - Repeat with Cnd=1 → reg5=120.
- popq %rsp collision: icode=B, rA=4, valE=0x108, valM=0xABC → reg4=0xABC. With rA=3 instead: reg4=0x108, reg3=0xABC.
- Status and sticky halt:
  - icode=0 → stat=2, halted=1.
  - Then irmovq rB=1, valE=7 → reg1 unchanged, retire_cnt unchanged.
  - After reset, icode=5 with dmem_error=1 → stat=3, rA not written.
  - After reset, icode=0xC → stat=4.
- Bypass:
  - With WB_BYPASS_EN: icode=3, rB=6, valE=99 strobed with srcB=6 → valB_rd=99 in the same cycle.
  - Without the macro: valB_rd=0 in that cycle and 99 after the edge.
